lookahead_routing_pipe: RTL and testbench
=========================================

Name: lookahead_routing_pipe

Overview:
Parametrised, pipelined successor to the single-hop lookahead routing logic, instantiated once per router input port. Accepts flits over a valid/ready handshake and computes the next-hop one-hot routing once per packet, on the head flit. Holds that routing for body and tail flits and forwards every flit through one registered output stage. Adds a selectable dimension order, mesh-bound checking and error reporting.

Parameters:
XW, 3, x coordinate width (bits)
YW, 3, y coordinate width (bits)
MESH_X, 8, mesh columns; legal x is 0..MESH_X-1
MESH_Y, 8, mesh rows; legal y is 0..MESH_Y-1
DIM_ORDER, 0, 0 = X first (west/east, then north/south); 1 = Y first
DATA_W, 32, opaque payload width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
position_x  in  XW  router x; static after init
position_y  in  YW  router y; static after init
in_valid  in  1  input flit valid
in_ready  out  1  input flit accepted when in_valid && in_ready
in_head  in  1  head flit
in_tail  in  1  tail flit; head && tail is a single-flit packet
in_dest_x  in  XW  destination x; sampled on head only
in_dest_y  in  YW  destination y; sampled on head only
in_routing  in  5  one-hot current hop {Local,E,W,S,N} = bits 4..0
in_data  in  DATA_W  payload
out_valid  out  1  output flit valid
out_ready  in  1  downstream ready
out_routing  out  5  one-hot next-hop routing
out_head  out  1  registered in_head
out_tail  out  1  registered in_tail
out_data  out  DATA_W  registered payload
err  out  1  one-cycle pulse on any error below
err_count  out  8  saturating error count

Behaviour:
- Reset (rst=0, async): FSM=INIT; out_valid=0, out_routing=5'b10000, out_head=0, out_tail=0, out_data=0, err=0, err_count=0, in_ready=0.
- Next-position registers:
  - next_pos_q[N,S,W,E] = position ±1 on the relevant axis, registered every cycle.
  - Routing always uses next_pos_q, never raw position.
- FSM:
  - INIT -> IDLE after exactly one cycle out of reset, so next_pos_q is valid. in_ready=0 in INIT.
  - IDLE: head accepted and not tail -> IN_PKT; head && tail -> stay IDLE.
  - IN_PKT: tail accepted -> IDLE.
- Handshake:
  - in_ready = (state!=INIT) && (!out_valid || out_ready).
  - Latency is 1 cycle, accepted flit to out_valid.
  - Output fields hold stable while out_valid && !out_ready.
  - Full throughput of 1 flit/cycle when out_ready=1.
- Head routing, from the selected next_pos_q (p) and dest (d):
  - DIM_ORDER=0: p.x>d.x -> W; p.x<d.x -> E; else p.y>d.y -> N; p.y<d.y -> S; else Local.
  - DIM_ORDER=1: Y comparisons first, then X.
  - Result latched in route_q.
  - Body/tail flits use route_q; their in_dest_* and in_routing are ignored.
- Errors (each sets err for one cycle and increments err_count, saturating at 255):
  - (a) Head with dest_x >= MESH_X or dest_y >= MESH_Y -> routing Local.
  - (b) Head with in_routing not one-hot, or Local -> routing Local.
  - (c) Selected next position off-mesh: W from x=0, N from y=0, E from x=MESH_X-1, S from y=MESH_Y-1 -> routing Local.
  - (d) Non-head flit in IDLE -> flit consumed and dropped; no out_valid.
  - (e) Head in IN_PKT -> treated as a new head (prior packet aborted), flit forwarded.
- Simultaneous errors count once per flit.
- Coordinate arithmetic is in XW/YW bits; off-mesh is decided by the check in (c) before wrap-around.
- Reset mid-packet: all state cleared; the next accepted flit must be a head.

Optional Feature:
LOOKAHEAD_ERR_CNT_EN
- Defined: err_count is implemented as specified.
- Undefined: counter is removed and err_count is tied to 8'd0; the err pulse is unchanged.

Test Plan:
- Reset release with in_valid=1: in_ready=0 in the first cycle, 1 in the second; out_routing=5'b10000 throughout reset.
- DIM_ORDER=0, position (2,2), head E, dest (5,1): out_routing=E (5'b01000) one cycle later. Then body and tail with dest (0,0) -> both E; FSM returns to IDLE.
- DIM_ORDER=1, position (2,2), head E, dest (5,1): out_routing=N (5'b00001). Head W to dest (1,2) -> Local (5'b10000).
- Back-pressure: out_ready=0 for 3 cycles with 2 flits offered -> in_ready=0, outputs stable; out_ready=1 -> both delivered in order, 1/cycle.
- Errors at position (0,0): head W -> Local, err=1. Head dest (9,0) with MESH_X=8 -> err. Body in IDLE -> dropped, err. err_count=3.
- 260 error flits -> err_count=255; without LOOKAHEAD_ERR_CNT_EN, err_count=0 throughout.

Source files
------------

// File: rtl/lookahead_routing_pipe.sv
// Per-input-port lookahead routing stage. The next-hop one-hot is computed on head flits and held for body/tail flits.
// Latency: 1 cycle from accepted flit to out_valid. in_ready is low while the output is stalled. LOOKAHEAD_ERR_CNT_EN enables err_count.
module lookahead_routing_pipe #(
  parameter int XW        = 3,
  parameter int YW        = 3,
  parameter int MESH_X    = 8,
  parameter int MESH_Y    = 8,
  parameter int DIM_ORDER = 0,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XW-1:0]     position_x,
  input  logic [YW-1:0]     position_y,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_head,
  input  logic              in_tail,
  input  logic [XW-1:0]     in_dest_x,
  input  logic [YW-1:0]     in_dest_y,
  input  logic [4:0]        in_routing,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_routing,
  output logic              out_head,
  output logic              out_tail,
  output logic [DATA_W-1:0] out_data,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_W = 5'b00100;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  typedef enum logic [1:0] {S_INIT = 2'd0, S_IDLE = 2'd1, S_PKT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [3:0][XW-1:0]  np_x_q, np_x_d;
  logic [3:0][YW-1:0]  np_y_q, np_y_d;
  logic [3:0]          off_q, off_d;
  logic [4:0]          route_q, route_d;
  logic                out_valid_q, out_valid_d;
  logic [4:0]          out_routing_q, out_routing_d;
  logic                out_head_q, out_head_d;
  logic                out_tail_q, out_tail_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                err_q, err_d;

  logic                dir_ok;
  logic [1:0]          sel;
  logic [XW-1:0]       p_x;
  logic [YW-1:0]       p_y;
  logic                dest_bad;
  logic                head_err;
  logic [4:0]          x_rt, y_rt, head_rt;
  logic                acc, drop, flit_err;

  // Index 0..3 follows the in_routing bit order: N, S, W, E.
  always_comb begin
    np_x_d    = {4{position_x}};
    np_y_d    = {4{position_y}};
    np_y_d[0] = position_y - YW'(1);
    np_y_d[1] = position_y + YW'(1);
    np_x_d[2] = position_x - XW'(1);
    np_x_d[3] = position_x + XW'(1);
    off_d[0]  = (position_y == '0);
    off_d[1]  = (position_y == YW'(MESH_Y - 1));
    off_d[2]  = (position_x == '0);
    off_d[3]  = (position_x == XW'(MESH_X - 1));
  end

  always_comb begin
    dir_ok = 1'b1;
    sel    = 2'd0;
    case (in_routing)
      R_N:     sel = 2'd0;
      R_S:     sel = 2'd1;
      R_W:     sel = 2'd2;
      R_E:     sel = 2'd3;
      default: dir_ok = 1'b0;
    endcase
    p_x      = np_x_q[sel];
    p_y      = np_y_q[sel];
    dest_bad = (32'(in_dest_x) >= 32'(MESH_X)) || (32'(in_dest_y) >= 32'(MESH_Y));
    head_err = !dir_ok || dest_bad || off_q[sel];
    x_rt     = (p_x > in_dest_x) ? R_W : (p_x < in_dest_x) ? R_E : R_L;
    y_rt     = (p_y > in_dest_y) ? R_N : (p_y < in_dest_y) ? R_S : R_L;
    if (head_err)
      head_rt = R_L;
    else if (DIM_ORDER == 0)
      head_rt = (x_rt != R_L) ? x_rt : y_rt;
    else
      head_rt = (y_rt != R_L) ? y_rt : x_rt;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: if (acc && in_head && !in_tail) state_d = S_PKT;
      S_PKT:  if (acc) state_d = in_tail ? S_IDLE : S_PKT;
      default: state_d = S_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q != S_INIT) && (!out_valid_q || out_ready);
  end

  assign acc      = in_valid && in_ready;
  assign drop     = acc && !in_head && (state_q == S_IDLE);
  // A head arriving mid-packet aborts the old packet but is still routed and forwarded.
  assign flit_err = drop || (acc && in_head && (head_err || (state_q == S_PKT)));

  always_comb begin
    route_d       = route_q;
    out_valid_d   = out_valid_q;
    out_routing_d = out_routing_q;
    out_head_d    = out_head_q;
    out_tail_d    = out_tail_q;
    out_data_d    = out_data_q;
    err_d         = flit_err;
    if (out_ready) out_valid_d = 1'b0;
    if (acc && in_head) route_d = head_rt;
    if (acc) begin
      out_valid_d = !drop;
      if (!drop) begin
        out_routing_d = in_head ? head_rt : route_q;
        out_head_d    = in_head;
        out_tail_d    = in_tail;
        out_data_d    = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      np_x_q        <= '0;
      np_y_q        <= '0;
      off_q         <= '0;
      route_q       <= R_L;
      out_valid_q   <= 1'b0;
      out_routing_q <= R_L;
      out_head_q    <= 1'b0;
      out_tail_q    <= 1'b0;
      out_data_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      np_x_q        <= np_x_d;
      np_y_q        <= np_y_d;
      off_q         <= off_d;
      route_q       <= route_d;
      out_valid_q   <= out_valid_d;
      out_routing_q <= out_routing_d;
      out_head_q    <= out_head_d;
      out_tail_q    <= out_tail_d;
      out_data_q    <= out_data_d;
      err_q         <= err_d;
    end
  end

`ifdef LOOKAHEAD_ERR_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_d && (cnt_q != 8'hff)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign out_valid   = out_valid_q;
  assign out_routing = out_routing_q;
  assign out_head    = out_head_q;
  assign out_tail    = out_tail_q;
  assign out_data    = out_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lookahead_routing_pipe.sv
// Directed bench: two instances (X-first and Y-first) share one stimulus stream on a 4-bit-coordinate 8x8 mesh.
module tb_lookahead_routing_pipe;

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_W = 5'b00100;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  logic        clk;
  logic        rst;
  logic [3:0]  position_x, position_y;
  logic        in_valid, in_head, in_tail;
  logic [3:0]  in_dest_x, in_dest_y;
  logic [4:0]  in_routing;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_head0, out_tail0, err0;
  logic [4:0]  out_routing0;
  logic [31:0] out_data0;
  logic [7:0]  err_count0;
  logic        in_ready1, out_valid1, out_head1, out_tail1, err1;
  logic [4:0]  out_routing1;
  logic [31:0] out_data1;
  logic [7:0]  err_count1;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  lookahead_routing_pipe #(.XW(4), .YW(4), .MESH_X(8), .MESH_Y(8), .DIM_ORDER(0), .DATA_W(32)) dut0 (
    .clk(clk), .rst(rst), .position_x(position_x), .position_y(position_y),
    .in_valid(in_valid), .in_ready(in_ready0), .in_head(in_head), .in_tail(in_tail),
    .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .in_routing(in_routing), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_routing(out_routing0),
    .out_head(out_head0), .out_tail(out_tail0), .out_data(out_data0),
    .err(err0), .err_count(err_count0)
  );

  lookahead_routing_pipe #(.XW(4), .YW(4), .MESH_X(8), .MESH_Y(8), .DIM_ORDER(1), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst), .position_x(position_x), .position_y(position_y),
    .in_valid(in_valid), .in_ready(in_ready1), .in_head(in_head), .in_tail(in_tail),
    .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .in_routing(in_routing), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_routing(out_routing1),
    .out_head(out_head1), .out_tail(out_tail1), .out_data(out_data1),
    .err(err1), .err_count(err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt();
`ifdef LOOKAHEAD_ERR_CNT_EN
    return (ecnt > 255) ? 8'd255 : 8'(ecnt);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk_rdy(input string tag, input logic exp);
    chk_b({tag, ".rdy0"}, in_ready0, exp);
    chk_b({tag, ".rdy1"}, in_ready1, exp);
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [4:0] r0, input logic [4:0] r1,
                            input logic hd, input logic tl, input logic [31:0] dat, input logic e);
    chk_b({tag, ".vld0"}, out_valid0, vld);
    chk_b({tag, ".vld1"}, out_valid1, vld);
    if (vld) begin
      chk_r({tag, ".rt0"}, out_routing0, r0);
      chk_r({tag, ".rt1"}, out_routing1, r1);
      chk_b({tag, ".head0"}, out_head0, hd);
      chk_b({tag, ".head1"}, out_head1, hd);
      chk_b({tag, ".tail0"}, out_tail0, tl);
      chk_b({tag, ".tail1"}, out_tail1, tl);
      chk_d({tag, ".data0"}, out_data0, dat);
      chk_d({tag, ".data1"}, out_data1, dat);
    end
    chk_b({tag, ".err0"}, err0, e);
    chk_b({tag, ".err1"}, err1, e);
    chk_c({tag, ".cnt0"}, err_count0, exp_cnt());
    chk_c({tag, ".cnt1"}, err_count1, exp_cnt());
  endtask

  task automatic drive(input logic hd, input logic tl, input logic [4:0] rt,
                       input logic [3:0] dx, input logic [3:0] dy, input logic [31:0] dat);
    in_valid   = 1'b1;
    in_head    = hd;
    in_tail    = tl;
    in_routing = rt;
    in_dest_x  = dx;
    in_dest_y  = dy;
    in_data    = dat;
  endtask

  initial begin
    rst        = 1'b0;
    out_ready  = 1'b1;
    position_x = 4'd2;
    position_y = 4'd2;
    drive(1'b1, 1'b0, R_E, 4'd5, 4'd1, 32'h0000_00A1);
    tick();
    tick();

    // Reset state with a head already offered.
    chk_rdy("rst", 1'b0);
    chk_r("rst.rt0", out_routing0, R_L);
    chk_r("rst.rt1", out_routing1, R_L);
    chk_d("rst.data0", out_data0, 32'd0);
    chk_b("rst.head0", out_head0, 1'b0);
    chk_b("rst.tail0", out_tail0, 1'b0);
    expect_out("rst", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b0);

    rst = 1'b1;
    #1;
    chk_rdy("init", 1'b0);
    tick();
    chk_rdy("idle", 1'b1);
    tick();
    expect_out("head_e", 1'b1, R_E, R_N, 1'b1, 1'b0, 32'h0000_00A1, 1'b0);

    drive(1'b0, 1'b0, 5'b00011, 4'd0, 4'd0, 32'h0000_00A2);
    tick();
    expect_out("body", 1'b1, R_E, R_N, 1'b0, 1'b0, 32'h0000_00A2, 1'b0);

    drive(1'b0, 1'b1, 5'b00000, 4'd0, 4'd0, 32'h0000_00A3);
    tick();
    expect_out("tail", 1'b1, R_E, R_N, 1'b0, 1'b1, 32'h0000_00A3, 1'b0);

    drive(1'b1, 1'b1, R_W, 4'd1, 4'd2, 32'h0000_00A4);
    tick();
    expect_out("w_local", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00A4, 1'b0);

    // Stall with a two-flit packet waiting.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, R_E, 4'd5, 4'd2, 32'h0000_00B1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy("bp_stall", 1'b0);
      tick();
      expect_out("bp_hold", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00A4, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk_rdy("bp_go", 1'b1);
    tick();
    expect_out("bp_b1", 1'b1, R_E, R_E, 1'b1, 1'b0, 32'h0000_00B1, 1'b0);
    drive(1'b0, 1'b1, R_N, 4'd0, 4'd0, 32'h0000_00B2);
    #1;
    chk_rdy("bp_b2", 1'b1);
    tick();
    expect_out("bp_b2", 1'b1, R_E, R_E, 1'b0, 1'b1, 32'h0000_00B2, 1'b0);
    in_valid = 1'b0;
    tick();
    expect_out("drain", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b0);

    // Error cases from the mesh corner.
    position_x = 4'd0;
    position_y = 4'd0;
    tick();
    drive(1'b1, 1'b1, R_W, 4'd3, 4'd3, 32'h0000_00C1);
    tick();
    ecnt++;
    expect_out("off_w", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00C1, 1'b1);
    drive(1'b1, 1'b1, R_S, 4'd9, 4'd0, 32'h0000_00C2);
    tick();
    ecnt++;
    expect_out("dest_x", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00C2, 1'b1);
    drive(1'b0, 1'b0, R_E, 4'd3, 4'd3, 32'h0000_00C3);
    tick();
    ecnt++;
    expect_out("drop", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, R_E, 4'd3, 4'd0, 32'h0000_00C4);
    tick();
    expect_out("pkt_head", 1'b1, R_E, R_E, 1'b1, 1'b0, 32'h0000_00C4, 1'b0);
    drive(1'b1, 1'b1, R_E, 4'd1, 4'd0, 32'h0000_00C5);
    tick();
    ecnt++;
    expect_out("re_head", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00C5, 1'b1);
    drive(1'b1, 1'b1, 5'b00011, 4'd2, 4'd2, 32'h0000_00C6);
    tick();
    ecnt++;
    expect_out("not_1hot", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00C6, 1'b1);
    drive(1'b1, 1'b1, R_L, 4'd2, 4'd2, 32'h0000_00C7);
    tick();
    ecnt++;
    expect_out("rt_local", 1'b1, R_L, R_L, 1'b1, 1'b1, 32'h0000_00C7, 1'b1);

    // Saturate the counter with dropped body flits.
    drive(1'b0, 1'b0, R_E, 4'd0, 4'd0, 32'h0000_00D0);
    for (int i = 0; i < 260; i++) begin
      tick();
      ecnt++;
    end
    expect_out("flood", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    expect_out("quiet", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a packet.
    drive(1'b1, 1'b0, R_E, 4'd3, 4'd0, 32'h0000_00E1);
    tick();
    expect_out("pre_rst", 1'b1, R_E, R_E, 1'b1, 1'b0, 32'h0000_00E1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    ecnt = 0;
    #1;
    chk_r("mid_rst.rt0", out_routing0, R_L);
    expect_out("mid_rst", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    drive(1'b0, 1'b1, R_E, 4'd3, 4'd0, 32'h0000_00E2);
    tick();
    ecnt++;
    expect_out("post_rst", 1'b0, R_L, R_L, 1'b0, 1'b0, 32'd0, 1'b1);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
